mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//   Parallel-to-serial scan stage that sits directly upstream of mux8x1.
//   Accepts a WIDTH-bit word over a valid/ready handshake and registers it.
//   Drives the word on mux_in and steps sel through every bit index, one bit per accepted beat.
//   Presents the selected bit on serial_out with a bit_valid/bit_ready handshake toward the consumer.
// PARAMETERS
//   WIDTH      8   word width; must be a power of 2 and >= 2
//   SEL_W      3   select width, equal to $clog2(WIDTH)
//   LSB_FIRST  1   1: sel counts 0 -> WIDTH-1; 0: sel counts WIDTH-1 -> 0
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-high reset
//   in_valid    in   1      data_in is valid
//   in_ready    out  1      block can accept a word (high only in IDLE)
//   data_in     in   WIDTH  word to serialise
//   mux_in      out  WIDTH  registered word; connects to mux8x1 .in
//   sel         out  SEL_W  registered bit index; connects to mux8x1 .sel
//   serial_out  out  1      mux_in[sel]; the local copy of the mux8x1 output
//   bit_valid   out  1      serial_out carries a valid bit (high in SHIFT)
//   bit_ready   in   1      consumer accepts serial_out this cycle
//   done        out  1      one-cycle pulse after the last bit is accepted
//   busy        out  1      state != IDLE
// BEHAVIOUR
//   - States: IDLE, SHIFT, DONE. All state and datapath registers reset asynchronously.
//   - Reset values: state=IDLE, mux_in=0, sel=0, serial_out=0, bit_valid=0, done=0, busy=0, in_ready=1.
//   - in_ready, bit_valid, done and busy are decoded from state only, with no input-to-output combinational path.
//   - serial_out = mux_in[sel] when bit_valid=1, and 0 otherwise.
//   - IDLE: in_valid && in_ready at a rising edge does the following:
//       - mux_in <= data_in;
//       - sel <= (LSB_FIRST ? 0 : WIDTH-1);
//       - the state goes to SHIFT.
//   - SHIFT: a beat is bit_valid && bit_ready at a rising edge.
//       - On a beat where sel is not the last index, sel steps by +1 (LSB_FIRST=1) or -1 (LSB_FIRST=0).
//       - The last index is WIDTH-1 when LSB_FIRST=1 and 0 when LSB_FIRST=0.
//       - On the beat at the last index, the state goes to DONE and sel holds its value.
//   - Backpressure: while bit_ready=0, sel, mux_in and serial_out hold their values.
//   - DONE: done=1 for exactly one cycle, then the state goes unconditionally to IDLE.
//       - mux_in and sel keep their last values in DONE and in the following IDLE cycles.
//   - Latency with bit_ready tied to 1:
//       - the accept edge is T;
//       - bits are valid during cycles T+1 to T+WIDTH;
//       - done is high in cycle T+WIDTH+1;
//       - in_ready is high again from cycle T+WIDTH+2.
//   - Minimum spacing between two accepted words is WIDTH+2 cycles.
//   - in_valid and data_in are ignored outside IDLE; any word offered then is neither latched nor dropped silently.
//     The source must hold in_valid until in_ready.
//   - data_in changing after the accept edge has no effect on the word being shifted.
//   - Asserting rst mid-SHIFT or in DONE aborts the word: no done pulse, and registers return to reset values immediately.
//   - sel never leaves the range 0..WIDTH-1, so there is no wrap-around.
// TESTING
//   - Reset: assert rst for 3 cycles -> in_ready=1, bit_valid=0, done=0, sel=0, mux_in=0 while rst is high.
//   - LSB_FIRST=1, bit_ready=1, load 8'b01010101:
//       - sel reads 0..7 in consecutive cycles;
//       - serial_out reads 1,0,1,0,1,0,1,0;
//       - done pulses at T+9 and in_ready returns at T+10.
//   - LSB_FIRST=0, load 8'hA5 -> sel reads 7..0 and serial_out reads 1,0,1,0,0,1,0,1.
//   - Backpressure, load 8'hF0 and hold bit_ready=0 for 4 cycles at sel=3:
//       - sel=3 and serial_out=0 stay stable throughout;
//       - the sequence resumes at sel=4 with serial_out=1;
//       - the total time to done extends by 4 cycles.
//   - Load 8'h0F, then assert in_valid with data_in=8'hFF during SHIFT:
//       - the output bits are still 1,1,1,1,0,0,0,0;
//       - 8'hFF is accepted only in the IDLE cycle after done.
//   - Assert rst at sel=5 -> all outputs go to reset values at once and no done pulse follows.
//     A fresh load afterwards serialises correctly.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: parallel-to-serial scan stage feeding a mux8x1, stepping sel one bit per accepted beat
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   word handshake; data_in is the word to serialise
//   mux_in, sel         registered word and bit index toward the mux
//   serial_out          mux_in[sel] while bit_valid, else 0
//   bit_valid/bit_ready bit handshake toward the consumer
//   done, busy          end-of-word pulse and not-idle status
module mux_scan_sequencer #(
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(WIDTH),
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] sel,
  output logic             serial_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             done,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [SEL_W-1:0] FIRST_IDX = LSB_FIRST ? '0 : SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = LSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mux_in_q, mux_in_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic accept, beat, last;
  always_comb begin
    accept = (state_q == IDLE) && in_valid;
    beat = (state_q == SHIFT) && bit_ready;
    last = sel_q == LAST_IDX;
    state_d = accept ? SHIFT : (beat && last) ? DONE : (state_q == DONE) ? IDLE : state_q;
    mux_in_d = accept ? data_in : mux_in_q;
    sel_d = accept ? FIRST_IDX :
            (beat && !last) ? (LSB_FIRST ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1)) : sel_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mux_in_q <= '0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      mux_in_q <= mux_in_d;
      sel_q <= sel_d;
    end
  end
  // Handshake and status outputs come from the state register only, so no input reaches an output combinationally.
  assign in_ready = state_q == IDLE;
  assign bit_valid = state_q == SHIFT;
  assign done = state_q == DONE;
  assign busy = state_q != IDLE;
  assign mux_in = mux_in_q;
  assign sel = sel_q;
  assign serial_out = bit_valid & mux_in_q[sel_q];
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: scoreboard bench driving an LSB-first and an MSB-first instance with shared stimulus
module tb_mux_scan_sequencer;
  localparam int W = 8;
  typedef struct {
    int s;
    logic b;
    logic [W-1:0] w;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic bit_ready = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] mux_in_o[2];
  logic [2:0] sel_o[2];
  logic ir[2], so[2], bv[2], dn[2], by[2];
  int checks = 0;
  int failures = 0;
  bit started = 1'b0;
  int m_left = 0;
  bit m_done = 1'b0;
  exp_t q[2][$];

  always #5 clk = ~clk;

  mux_scan_sequencer #(.WIDTH(W), .SEL_W(3), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .data_in(data_in),
    .mux_in(mux_in_o[0]), .sel(sel_o[0]), .serial_out(so[0]), .bit_valid(bv[0]),
    .bit_ready(bit_ready), .done(dn[0]), .busy(by[0]));
  mux_scan_sequencer #(.WIDTH(W), .SEL_W(3), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .data_in(data_in),
    .mux_in(mux_in_o[1]), .sel(sel_o[1]), .serial_out(so[1]), .bit_valid(bv[1]),
    .bit_ready(bit_ready), .done(dn[1]), .busy(by[1]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word occupies WIDTH beats of output, then one done cycle, then idle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      q[0].delete();
      q[1].delete();
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      if (bit_ready) begin
        m_left <= m_left - 1;
        m_done <= (m_left == 1);
      end
    end else if (in_valid) begin
      m_left <= W;
      for (int j = 0; j < W; j++) begin
        exp_t e;
        e.s = j;
        e.b = data_in[j];
        e.w = data_in;
        q[0].push_back(e);
        e.s = W - 1 - j;
        e.b = data_in[W-1-j];
        q[1].push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("in_ready", int'(ir[i]), int'(m_left == 0 && !m_done));
        chk("bit_valid", int'(bv[i]), int'(m_left > 0));
        chk("done", int'(dn[i]), int'(m_done));
        chk("busy", int'(by[i]), int'(m_left > 0 || m_done));
        if (rst) begin
          chk("rst_sel", int'(sel_o[i]), 0);
          chk("rst_mux_in", int'(mux_in_o[i]), 0);
        end
        if (bv[i]) begin
          if (q[i].size() == 0) chk("unexpected_bit", 1, 0);
          else begin
            chk("sel", int'(sel_o[i]), q[i][0].s);
            chk("serial_out", int'(so[i]), int'(q[i][0].b));
            chk("mux_in", int'(mux_in_o[i]), int'(q[i][0].w));
            if (bit_ready) void'(q[i].pop_front());
          end
        end else chk("serial_idle", int'(so[i]), 0);
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    while (!ir[0] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 64) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] word, input int stall_at, input int stall_len,
                      input bit rnd, input bit pre, input logic [W-1:0] pre_word);
    int n = 0;
    int k = 0;
    int st = 0;
    bit stall;
    in_valid = 1'b1;
    data_in = word;
    wait_accept();
    in_valid = pre;
    data_in = pre ? pre_word : W'($urandom);
    while (!dn[0] && n < 100) begin
      stall = (k == stall_at) && (st < stall_len);
      if (stall) st++;
      bit_ready = rnd ? 1'($urandom_range(0, 1)) : !stall;
      if (bv[0] && bit_ready) k++;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("done_timeout", 1, 0);
    if (!rnd) begin
      chk("latency", n, W + stall_len);
      if (!pre) begin
        @(posedge clk); #1;
        chk("ready_back", int'(ir[0]), 1);
      end
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    started = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send(8'h55, -1, 0, 1'b0, 1'b0, '0);
    send(8'hA5, -1, 0, 1'b0, 1'b0, '0);
    send(8'hF0, 3, 4, 1'b0, 1'b0, '0);
    send(8'h0F, -1, 0, 1'b0, 1'b1, 8'hFF);
    send(8'hFF, -1, 0, 1'b0, 1'b0, '0);
    in_valid = 1'b1;
    data_in = 8'h3C;
    bit_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_sel", int'(sel_o[0]), 5);
    rst = 1'b1;
    #1;
    chk("abort_sel", int'(sel_o[0]), 0);
    chk("abort_valid", int'(bv[0]), 0);
    chk("abort_ready", int'(ir[0]), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", int'(dn[0]), 0);
    end
    send(8'h96, -1, 0, 1'b0, 1'b0, '0);
    repeat (25) begin
      send(W'($urandom), -1, 0, 1'b1, 1'b0, '0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("q_lsb_empty", q[0].size(), 0);
    chk("q_msb_empty", q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
